// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - E-stage issue/track controller for the multiply/divide unit
module mdu_issue_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_mdu_use,
  input  logic             e_valid,
  input  logic             e_flush,
  input  logic [3:0]       e_cls,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             mdu_busy,
  output logic             mdu_start,
  output logic [2:0]       mdu_op,
  output logic             mdu_hiwr,
  output logic             mdu_lowr,
  output logic [31:0]      mdu_a,
  output logic [31:0]      mdu_b,
  output logic [1:0]       rd_sel,
  output logic             stall_d,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            err_nxt;
  logic            req, issue, cls_any, err_set, timeout;

  assign req     = e_valid & ~e_flush;
  assign issue   = req & (state == IDLE) & ~mdu_busy;
  assign cls_any = (e_cls >= 4'd1) && (e_cls <= 4'd8);
  assign err_set = req & cls_any & ((state != IDLE) | mdu_busy);
  // Fires on the MAX_WAIT-th cycle spent in either wait state.
  assign timeout = (state != IDLE) && (wait_cnt == WC_W'(MAX_WAIT - 1));

  assign mdu_a = e_rs;
  assign mdu_b = e_rt;

  always_comb begin
    mdu_start = 1'b0;
    mdu_op    = 3'b000;
    mdu_hiwr  = 1'b0;
    mdu_lowr  = 1'b0;
    rd_sel    = 2'b00;
    if (issue) begin
      case (e_cls)
        4'd1:    begin mdu_start = 1'b1; mdu_op = 3'b000; end
        4'd2:    begin mdu_start = 1'b1; mdu_op = 3'b001; end
        4'd3:    begin mdu_start = 1'b1; mdu_op = 3'b010; end
        4'd4:    begin mdu_start = 1'b1; mdu_op = 3'b011; end
        4'd5:    mdu_hiwr = 1'b1;
        4'd6:    mdu_lowr = 1'b1;
        4'd7:    rd_sel = 2'b01;
        4'd8:    rd_sel = 2'b10;
        default: ;
      endcase
    end
  end

  assign stall_d = d_mdu_use & ((state != IDLE) | mdu_start | mdu_busy);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err | err_set | timeout;
    case (state)
      IDLE: begin
        if (mdu_start) begin
          state_nxt    = WAIT_RISE;
          wait_cnt_nxt = '0;
        end
      end
      WAIT_RISE: begin
        wait_cnt_nxt = wait_cnt + WC_W'(1);
        if (timeout)       state_nxt = IDLE;
        else if (mdu_busy) state_nxt = WAIT_FALL;
      end
      WAIT_FALL: begin
        wait_cnt_nxt = wait_cnt + WC_W'(1);
        if (timeout || !mdu_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err      <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_d && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - self-checking bench for mdu_issue_ctrl
module tb_mdu_issue_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             d_mdu_use, e_valid, e_flush, mdu_busy;
  logic [3:0]       e_cls;
  logic [31:0]      e_rs, e_rt;
  logic             mdu_start, mdu_hiwr, mdu_lowr, stall_d, err;
  logic [2:0]       mdu_op;
  logic [31:0]      mdu_a, mdu_b;
  logic [1:0]       rd_sel;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_issue_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_mdu_use(d_mdu_use), .e_valid(e_valid),
    .e_flush(e_flush), .e_cls(e_cls), .e_rs(e_rs), .e_rt(e_rt),
    .mdu_busy(mdu_busy), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .mdu_hiwr(mdu_hiwr), .mdu_lowr(mdu_lowr), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .rd_sel(rd_sel), .stall_d(stall_d), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding op, whether its busy pulse has been seen, cycles waited.
  bit m_out = 0, m_seen = 0, m_err = 0;
  int m_elapsed = 0, m_scnt = 0;
  int c;
  bit x_req, x_iss, x_start, x_hiwr, x_lowr, x_stall;
  int x_op, x_rd;

  always @(negedge clk) begin
    c       = int'(e_cls);
    x_req   = e_valid && !e_flush;
    x_iss   = x_req && !m_out && !mdu_busy;
    x_start = x_iss && c >= 1 && c <= 4;
    x_op    = x_start ? c - 1 : 0;
    x_hiwr  = x_iss && c == 5;
    x_lowr  = x_iss && c == 6;
    x_rd    = !x_iss ? 0 : (c == 7) ? 1 : (c == 8) ? 2 : 0;
    x_stall = d_mdu_use && (m_out || x_start || mdu_busy);
    chk("start", 32'(mdu_start), 32'(x_start));
    chk("op", 32'(mdu_op), 32'(x_op));
    chk("hiwr", 32'(mdu_hiwr), 32'(x_hiwr));
    chk("lowr", 32'(mdu_lowr), 32'(x_lowr));
    chk("rd_sel", 32'(rd_sel), 32'(x_rd));
    chk("a", mdu_a, e_rs);
    chk("b", mdu_b, e_rt);
    chk("stall_d", 32'(stall_d), 32'(x_stall));
    chk("err", 32'(err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    if (reset) begin
      m_out = 0; m_seen = 0; m_err = 0; m_elapsed = 0; m_scnt = 0;
    end else begin
      if (x_req && c >= 1 && c <= 8 && (m_out || mdu_busy)) m_err = 1;
      if (x_stall && m_scnt < (1 << CNT_W) - 1) m_scnt++;
      if (x_start) begin
        m_out = 1; m_seen = 0; m_elapsed = 0;
      end else if (m_out) begin
        m_elapsed++;
        if (m_elapsed >= MAX_WAIT) begin
          m_out = 0; m_err = 1;
        end else if (!m_seen && mdu_busy) m_seen = 1;
        else if (m_seen && !mdu_busy) m_out = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic f, input logic [3:0] cl,
                     input logic [31:0] a, input logic [31:0] b, input logic busy);
    e_valid = v; e_flush = f; e_cls = cl; e_rs = a; e_rt = b; mdu_busy = busy;
  endtask

  // n busy cycles, then one quiet cycle that lets the tracker return to idle
  task automatic busy_run(input int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 0, 0, 0, 1);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; d_mdu_use = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    tick();
    reset = 1'b0;
    d_mdu_use = 1'b1;

    // mult, 5-cycle busy, then back-to-back multu
    drv(1, 0, 1, 32'd7, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    chk("mult_start", 32'(mdu_start), 1);
    chk("mult_op", 32'(mdu_op), 0);
    chk("mult_b", mdu_b, 32'hFFFF_FFFD);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drv(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("mult_busy_nostart", 32'(mdu_start), 0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mult_t6_stall", 32'(stall_d), 1);
    tick();
    drv(1, 0, 2, 32'd5, 32'd6, 0);
    @(negedge clk);
    chk("b2b_start", 32'(mdu_start), 1);
    chk("b2b_op", 32'(mdu_op), 1);
    tick();
    busy_run(3);

    // div with D-stage stall, then mflo
    do_reset();
    drv(1, 0, 3, 32'd100, 32'd7, 0);
    @(negedge clk);
    chk("div_op", 32'(mdu_op), 2);
    tick();
    busy_run(10);
    drv(1, 0, 8, 0, 0, 0);
    @(negedge clk);
    chk("mflo_rd", 32'(rd_sel), 2);
    chk("mflo_stall", 32'(stall_d), 0);
    chk("div_stall_cnt", 32'(stall_cnt), 12);
    tick();
    drv(1, 0, 4, 32'd9, 32'd2, 0);
    tick();
    busy_run(3);
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("cnt_sat", 32'(stall_cnt), 15);
    tick();

    // mthi / mtlo / mfhi / out-of-range class
    drv(1, 0, 5, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    chk("mthi_wr", 32'(mdu_hiwr), 1);
    chk("mthi_a", mdu_a, 32'hDEAD_BEEF);
    chk("mthi_nostart", 32'(mdu_start), 0);
    tick();
    drv(1, 0, 6, 32'h1234_5678, 0, 0);
    @(negedge clk);
    chk("mtlo_wr", 32'(mdu_lowr), 1);
    chk("mtlo_nohi", 32'(mdu_hiwr), 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mtx_idle", 32'(stall_d), 0);
    tick();
    drv(1, 0, 7, 0, 0, 0);
    @(negedge clk);
    chk("mfhi_rd", 32'(rd_sel), 1);
    tick();
    drv(1, 0, 12, 0, 0, 0);
    tick();

    // flush
    drv(1, 1, 3, 32'd1, 32'd1, 0);
    @(negedge clk);
    chk("flush_nostart", 32'(mdu_start), 0);
    chk("flush_nostall", 32'(stall_d), 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_idle", 32'(stall_d), 0);
    tick();

    // protocol error: mult while waiting for busy to fall
    drv(1, 0, 1, 32'd3, 32'd4, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    tick();
    drv(1, 0, 1, 32'd3, 32'd4, 1);
    @(negedge clk);
    chk("perr_nostart", 32'(mdu_start), 0);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("perr_err", 32'(err), 1);
    tick();
    busy_run(2);

    // timeout: busy never rises
    do_reset();
    @(negedge clk);
    chk("to_err_clr", 32'(err), 0);
    drv(1, 0, 1, 0, 0, 0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      drv(0, 0, 0, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    chk("to_last_wait", 32'(stall_d), 1);
    tick();
    @(negedge clk);
    chk("to_idle", 32'(stall_d), 0);
    chk("to_err", 32'(err), 1);
    tick();

    // reset in the middle of an operation
    drv(1, 0, 3, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rmid_stall", 32'(stall_d), 0);
    chk("rmid_err", 32'(err), 0);
    chk("rmid_cnt", 32'(stall_cnt), 0);
    tick();
    drv(1, 0, 1, 32'd2, 32'd2, 0);
    @(negedge clk);
    chk("rmid_reissue", 32'(mdu_start), 1);
    tick();
    busy_run(2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
